mem_arbiter: RTL and testbench

- Round-robin arbiter that shares one single-port 256x8 synchronous RAM among NUM_REQ requesters.
- Accepts per-requester read/write requests, drives the RAM control pins (ce, we, addr_in, data_in) and returns read data with a valid strobe.
- Sits between client blocks and the RAM instance. Serialises all accesses at one access every two cycles.

---
 rtl/mem_arbiter_if.sv | 44 ++++
 rtl/mem_arbiter.sv | 122 ++++++++++++
 tb/tb_mem_arbiter.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
//------------------------------------------------------------------------------
// Module      : mem_arbiter_if
// Description : Bundle of the requester-side handshake and the RAM control
//               bus served by mem_arbiter.
//               Requester side : req, req_we, req_addr, req_wdata (to arbiter)
//                                gnt, rvalid, rdata           (from arbiter)
//               RAM side       : mem_ce, mem_we, mem_addr, mem_wdata (to RAM)
//                                mem_rdata                    (from RAM)
//               modport slave  : arbiter view
//               modport master : client/RAM view (the environment)
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface mem_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8
);
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ-1:0]        req_we;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_wdata;
    logic [NUM_REQ-1:0]        gnt;
    logic [NUM_REQ-1:0]        rvalid;
    logic [DATA_W-1:0]         rdata;
    logic                      mem_ce;
    logic                      mem_we;
    logic [ADDR_W-1:0]         mem_addr;
    logic [DATA_W-1:0]         mem_wdata;
    logic [DATA_W-1:0]         mem_rdata;

    modport slave (
        input  req, req_we, req_addr, req_wdata, mem_rdata,
        output gnt, rvalid, rdata, mem_ce, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output req, req_we, req_addr, req_wdata, mem_rdata,
        input  gnt, rvalid, rdata, mem_ce, mem_we, mem_addr, mem_wdata
    );
endinterface

`default_nettype wire

// File: rtl/mem_arbiter.sv
//------------------------------------------------------------------------------
// Module      : mem_arbiter
// Description : Round-robin arbiter sharing one single-port synchronous RAM
//               among NUM_REQ requesters, one access every two cycles.
// Ports       : clk_i  - system clock, rising edge
//               rst_ni - asynchronous reset, active low
//               bus    - mem_arbiter_if.slave (requester handshake + RAM pins)
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mem_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8
) (
    input  wire logic      clk_i,
    input  wire logic      rst_ni,
    mem_arbiter_if.slave   bus
);
    localparam int PTR_W = $clog2(NUM_REQ);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [PTR_W-1:0]    ptr_q, ptr_d;
    logic [NUM_REQ-1:0]  gnt_q, gnt_d;
    logic [NUM_REQ-1:0]  rvalid_q, rvalid_d;
    logic                ce_q, ce_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;

    logic                win_found;
    logic [PTR_W-1:0]    win_idx;

    // Rotating priority search starting at ptr_q; wraps modulo NUM_REQ so
    // non-power-of-two requester counts are handled.
    always_comb begin
        int idx;
        win_found = 1'b0;
        win_idx   = '0;
        idx       = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!win_found && bus.req[idx]) begin
                win_found = 1'b1;
                win_idx   = idx[PTR_W-1:0];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        gnt_d    = '0;
        rvalid_d = '0;
        ce_d     = 1'b0;
        we_d     = 1'b0;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        unique case (state_q)
            IDLE: begin
                if (win_found) begin
                    ce_d    = 1'b1;
                    we_d    = bus.req_we[win_idx];
                    addr_d  = bus.req_addr[win_idx*ADDR_W +: ADDR_W];
                    wdata_d = bus.req_wdata[win_idx*DATA_W +: DATA_W];
                    gnt_d   = NUM_REQ'(1) << win_idx;
                    ptr_d   = (win_idx == PTR_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                // The granted requester is still encoded in gnt_q, so the
                // read-valid pulse is simply the grant delayed one cycle.
                rvalid_d = we_q ? '0 : gnt_q;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            gnt_q    <= '0;
            rvalid_q <= '0;
            ce_q     <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            gnt_q    <= gnt_d;
            rvalid_q <= rvalid_d;
            ce_q     <= ce_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.rvalid    = rvalid_q;
    assign bus.rdata     = bus.mem_rdata;
    assign bus.mem_ce    = ce_q;
    assign bus.mem_we    = we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
//------------------------------------------------------------------------------
// Module      : tb_mem_arbiter
// Description : Directed self-checking bench for mem_arbiter with a
//               behavioural 256x8 registered-read RAM.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_mem_arbiter;
    localparam int NUM_REQ = 4;
    localparam int ADDR_W  = 8;
    localparam int DATA_W  = 8;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    logic [7:0] ram [0:255];
    logic [7:0] ram_rd_q;

    mem_arbiter_if #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_arbiter #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM: writes and reads sampled on the rising edge, read data registered.
    always @(posedge clk) begin
        if (bus.mem_ce) begin
            if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
            else            ram_rd_q <= ram[bus.mem_addr];
        end
    end
    assign bus.mem_rdata = ram_rd_q;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] init_val(input int a);
        logic [7:0] v;
        v = 8'(a) ^ 8'h5A;
        return v;
    endfunction

    initial begin
        checks   = 0;
        failures = 0;
        ram_rd_q = '0;
        for (int i = 0; i < 256; i++) ram[i] = init_val(i);

        // Reset held with all requesters asking to read 0x40+i.
        rst_n         = 1'b0;
        bus.req       = 4'b1111;
        bus.req_we    = 4'b0000;
        bus.req_addr  = {8'h43, 8'h42, 8'h41, 8'h40};
        bus.req_wdata = '0;
        for (int c = 0; c < 3; c++) begin
            step();
            chk("rst_gnt",    bus.gnt,    0);
            chk("rst_ce",     bus.mem_ce, 0);
            chk("rst_rvalid", bus.rvalid, 0);
        end
        chk("rst_addr", bus.mem_addr, 0);
        rst_n = 1'b1;

        // Contention: everyone keeps requesting; order 0,1,2,3,0.
        for (int g = 0; g < 5; g++) begin
            step();
            chk("cont_gnt",  bus.gnt,      32'(1) << (g % 4));
            chk("cont_ce",   bus.mem_ce,   1);
            chk("cont_addr", bus.mem_addr, 8'h40 + 8'(g % 4));
            step();
            chk("cont_gnt0",   bus.gnt,    0);
            chk("cont_ce0",    bus.mem_ce, 0);
            chk("cont_rvalid", bus.rvalid, 32'(1) << (g % 4));
            chk("cont_rdata",  bus.rdata,  init_val(8'h40 + (g % 4)));
        end

        // Rotation skip: ptr is 1, requesters 0 and 3 pending.
        bus.req = 4'b1001;
        step();
        chk("skip_gnt3", bus.gnt, 4'b1000);
        step();
        chk("skip_rv3",  bus.rvalid, 4'b1000);
        chk("skip_rd3",  bus.rdata,  init_val(8'h43));
        step();
        chk("skip_gnt0", bus.gnt, 4'b0001);
        step();
        chk("skip_rv0",  bus.rvalid, 4'b0001);
        // ptr must now be 1: with 0 and 1 both asking, 1 wins.
        bus.req = 4'b0011;
        step();
        chk("ptr_gnt1", bus.gnt, 4'b0010);
        bus.req = 4'b0000;
        step();
        chk("ptr_rv1",  bus.rvalid, 4'b0010);

        // Single write then read by requester 0.
        bus.req       = 4'b0001;
        bus.req_we    = 4'b0001;
        bus.req_addr  = {8'h00, 8'h00, 8'h00, 8'h10};
        bus.req_wdata = {8'h00, 8'h00, 8'h00, 8'hA5};
        step();
        chk("wr_gnt",   bus.gnt,       4'b0001);
        chk("wr_we",    bus.mem_we,    1);
        chk("wr_addr",  bus.mem_addr,  8'h10);
        chk("wr_wdata", bus.mem_wdata, 8'hA5);
        bus.req = 4'b0000;
        step();
        chk("wr_rvalid", bus.rvalid, 0);
        chk("wr_we0",    bus.mem_we, 0);
        chk("wr_hold",   bus.mem_addr, 8'h10);
        bus.req    = 4'b0001;
        bus.req_we = 4'b0000;
        step();
        chk("rd_gnt", bus.gnt,    4'b0001);
        chk("rd_we",  bus.mem_we, 0);
        bus.req = 4'b0000;
        step();
        chk("rd_rvalid", bus.rvalid, 4'b0001);
        chk("rd_rdata",  bus.rdata,  8'hA5);

        // Back-to-back: requester 1 reads 0x20, requester 2 writes 0x3C to 0x30.
        bus.req       = 4'b0110;
        bus.req_we    = 4'b0100;
        bus.req_addr  = {8'h00, 8'h30, 8'h20, 8'h00};
        bus.req_wdata = {8'h00, 8'h3C, 8'h00, 8'h00};
        step();
        chk("b2b_gnt1", bus.gnt, 4'b0010);
        bus.req = 4'b0100;
        step();
        chk("b2b_rv1",   bus.rvalid, 4'b0010);
        chk("b2b_rd1",   bus.rdata,  8'h7A);
        chk("b2b_gnt0",  bus.gnt,    0);
        step();
        chk("b2b_gnt2",  bus.gnt,    4'b0100);
        chk("b2b_we2",   bus.mem_we, 1);
        chk("b2b_rv0",   bus.rvalid, 0);
        bus.req = 4'b0000;
        step();
        chk("b2b_norv2", bus.rvalid, 0);
        chk("b2b_ram",   ram[8'h30], 8'h3C);

        // Reset during the ISSUE cycle of a read.
        bus.req      = 4'b0001;
        bus.req_we   = 4'b0000;
        bus.req_addr = {8'h00, 8'h00, 8'h00, 8'h55};
        step();
        chk("mid_gnt", bus.gnt,    4'b0001);
        chk("mid_ce",  bus.mem_ce, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_gnt_drop", bus.gnt,    0);
        chk("mid_ce_drop",  bus.mem_ce, 0);
        bus.req = 4'b0000;
        step();
        chk("mid_rv_rst", bus.rvalid, 0);
        rst_n = 1'b1;
        step();
        chk("mid_rv_rel", bus.rvalid, 0);
        chk("mid_gnt_rel", bus.gnt,   0);
        step();
        chk("mid_rv_rel2", bus.rvalid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
